// File: rtl/switch_mcu_pkg.sv
// Shared decode constants, slot counter idle value, sequencer state encoding and op-enable bundle.
package switch_mcu_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_SLTI    = 3'b010;
  localparam logic [2:0] F3_XORI    = 3'b100;
  localparam logic [2:0] F3_ORI     = 3'b110;
  localparam logic [2:0] F3_ANDI    = 3'b111;

  localparam logic [3:0] CNT_IDLE   = 4'hF;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic addi;
    logic slti;
    logic xori;
    logic ori;
    logic andi;
  } op_en_t;

endpackage

// File: rtl/switch_mcu_dec_fields.sv
// Combinational OP-IMM decode: instruction word to one-hot op enables, illegal flag and I-type fields.
module switch_mcu_dec_fields
  import switch_mcu_pkg::*;
(
  input  logic [31:0] instr,
  output op_en_t      en,
  output logic        illegal,
  output logic [11:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rd
);

  always_comb begin
    en      = '0;
    illegal = 1'b1;
    if (instr[6:0] == OPC_OP_IMM) begin
      illegal = 1'b0;
      case (instr[14:12])
        F3_ADDI: en.addi = 1'b1;
        F3_SLTI: en.slti = 1'b1;
        F3_XORI: en.xori = 1'b1;
        F3_ORI:  en.ori  = 1'b1;
        F3_ANDI: en.andi = 1'b1;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign imm = instr[31:20];
  assign rs1 = instr[19:15];
  assign rd  = instr[11:7];

endmodule

// File: rtl/switch_mcu_decoder.sv
// Fetch/decode sequencer: one instruction per SLOT_LEN+1 cycles, enables visible from cnt==0, ready only in FETCH.
// SWITCH_MCU_DEC_ILLEGAL_HALT_EN: an illegal instruction parks the sequencer in HALT until reset.
module switch_mcu_decoder
  import switch_mcu_pkg::*;
#(
  parameter int unsigned SLOT_LEN = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_instr_valid,
  input  logic [31:0] in_instr,
  output logic        out_instr_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_cycle_cnt,
  output logic        out_en_addi,
  output logic        out_en_slti,
  output logic        out_en_xori,
  output logic        out_en_ori,
  output logic        out_en_andi,
  output logic [11:0] out_imm_type_i,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic        out_halted
);

  localparam logic [3:0] CNT_LAST = 4'(SLOT_LEN - 1);

  state_t      state;
  op_en_t      en_q;
  op_en_t      dec_en;
  logic        dec_illegal;
  logic [11:0] dec_imm;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rd;

  switch_mcu_dec_fields u_fields (
    .instr   (in_instr),
    .en      (dec_en),
    .illegal (dec_illegal),
    .imm     (dec_imm),
    .rs1     (dec_rs1),
    .rd      (dec_rd)
  );

`ifdef SWITCH_MCU_DEC_ILLEGAL_HALT_EN
  logic slot_illegal;
  logic halted;
  assign out_halted = halted;
`else
  assign out_halted = 1'b0;
`endif

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state           <= ST_FETCH;
      out_instr_ready <= 1'b1;
      out_pc          <= RESET_PC;
      out_cycle_cnt   <= CNT_IDLE;
      en_q            <= '0;
      out_imm_type_i  <= '0;
      out_rs1         <= '0;
      out_rd          <= '0;
      out_illegal     <= 1'b0;
`ifdef SWITCH_MCU_DEC_ILLEGAL_HALT_EN
      slot_illegal    <= 1'b0;
      halted          <= 1'b0;
`endif
    end else begin
      case (state)
        ST_FETCH: begin
          if (in_instr_valid && out_instr_ready) begin
            state           <= ST_EXEC;
            out_instr_ready <= 1'b0;
            out_cycle_cnt   <= 4'd0;
            en_q            <= dec_en;
            out_imm_type_i  <= dec_imm;
            out_rs1         <= dec_rs1;
            out_rd          <= dec_rd;
            out_illegal     <= dec_illegal;
`ifdef SWITCH_MCU_DEC_ILLEGAL_HALT_EN
            slot_illegal    <= dec_illegal;
`endif
          end
        end
        ST_EXEC: begin
          // The illegal flag is only meaningful while cnt==0.
          out_illegal <= 1'b0;
          if (out_cycle_cnt == CNT_LAST) begin
            out_cycle_cnt  <= CNT_IDLE;
            en_q           <= '0;
            out_imm_type_i <= '0;
            out_rs1        <= '0;
            out_rd         <= '0;
`ifdef SWITCH_MCU_DEC_ILLEGAL_HALT_EN
            if (slot_illegal) begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              state           <= ST_FETCH;
              out_instr_ready <= 1'b1;
              out_pc          <= out_pc + 32'd4;
            end
`else
            state           <= ST_FETCH;
            out_instr_ready <= 1'b1;
            out_pc          <= out_pc + 32'd4;
`endif
          end else begin
            out_cycle_cnt <= out_cycle_cnt + 4'd1;
          end
        end
`ifdef SWITCH_MCU_DEC_ILLEGAL_HALT_EN
        ST_HALT: begin
          out_instr_ready <= 1'b0;
          halted          <= 1'b1;
        end
`endif
        default: begin
          state           <= ST_FETCH;
          out_instr_ready <= 1'b1;
          out_cycle_cnt   <= CNT_IDLE;
          en_q            <= '0;
          out_illegal     <= 1'b0;
        end
      endcase
    end
  end

  assign out_en_addi = en_q.addi;
  assign out_en_slti = en_q.slti;
  assign out_en_xori = en_q.xori;
  assign out_en_ori  = en_q.ori;
  assign out_en_andi = en_q.andi;

endmodule

// File: tb/tb_switch_mcu_decoder.sv
// Scoreboard bench for switch_mcu_decoder: driver pushes model expectations, negedge monitor pops and compares.
module tb_switch_mcu_decoder;

  localparam int          SLOT_LEN = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          PERIOD   = 10;
  localparam logic [3:0]  IDLE     = 4'hF;
  localparam logic [3:0]  LAST     = 4'(SLOT_LEN - 1);

  logic        in_clk;
  logic        in_rst;
  logic        in_instr_valid;
  logic [31:0] in_instr;
  logic        out_instr_ready;
  logic [31:0] out_pc;
  logic [3:0]  out_cycle_cnt;
  logic        out_en_addi, out_en_slti, out_en_xori, out_en_ori, out_en_andi;
  logic [11:0] out_imm_type_i;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rd;
  logic        out_illegal;
  logic        out_halted;
  logic [4:0]  en_v;

  switch_mcu_decoder #(.SLOT_LEN(SLOT_LEN), .RESET_PC(RESET_PC)) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_instr_valid  (in_instr_valid),
    .in_instr        (in_instr),
    .out_instr_ready (out_instr_ready),
    .out_pc          (out_pc),
    .out_cycle_cnt   (out_cycle_cnt),
    .out_en_addi     (out_en_addi),
    .out_en_slti     (out_en_slti),
    .out_en_xori     (out_en_xori),
    .out_en_ori      (out_en_ori),
    .out_en_andi     (out_en_andi),
    .out_imm_type_i  (out_imm_type_i),
    .out_rs1         (out_rs1),
    .out_rd          (out_rd),
    .out_illegal     (out_illegal),
    .out_halted      (out_halted)
  );

  assign en_v = {out_en_addi, out_en_slti, out_en_xori, out_en_ori, out_en_andi};

  typedef struct {
    logic [4:0]  en;
    logic        ill;
    logic        chk;
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [31:0] pc;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] exp_pc = RESET_PC;
  logic [3:0]  prev = IDLE;
  logic [3:0]  exp_next;
  bit          hold_mode = 0;
  bit          last_hold = 0;
  time         last_hs = 0;

  initial begin
    in_clk = 1'b0;
    forever #(PERIOD / 2) in_clk = ~in_clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode: OP-IMM funct3 picks one of five ops, everything else is illegal.
  function automatic exp_t model_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t       e;
    int         idx;
    logic [4:0] first;
    first = 5'b10000;
    idx   = -1;
    if (w[6:0] == 7'b0010011) begin
      case (w[14:12])
        3'd0: idx = 0;
        3'd2: idx = 1;
        3'd4: idx = 2;
        3'd6: idx = 3;
        3'd7: idx = 4;
        default: idx = -1;
      endcase
    end
    e.en  = (idx < 0) ? 5'd0 : (first >> idx);
    e.ill = (idx < 0);
    e.chk = (idx >= 0);
    e.imm = w[31:20];
    e.rs1 = w[19:15];
    e.rd  = w[11:7];
    e.pc  = pc;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [2:0] ok_f3 [5];
    logic [2:0] bad_f3 [3];
    int         r;
    ok_f3  = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
    bad_f3 = '{3'd1, 3'd3, 3'd5};
    r = $urandom_range(0, 3);
    if (r <= 1)
      return {12'($urandom), 5'($urandom), ok_f3[$urandom_range(0, 4)], 5'($urandom), 7'b0010011};
    else if (r == 2)
      return {12'($urandom), 5'($urandom), bad_f3[$urandom_range(0, 2)], 5'($urandom), 7'b0010011};
    else
      return $urandom;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cnt"}, 64'(out_cycle_cnt), 64'(IDLE));
    check({tag, "_ready"}, 64'(out_instr_ready), 64'd1);
    check({tag, "_pc"}, 64'(out_pc), 64'(RESET_PC));
    check({tag, "_en_fields"}, 64'({en_v, out_imm_type_i, out_rs1, out_rd}), 64'd0);
    check({tag, "_illegal_halted"}, 64'({out_illegal, out_halted}), 64'd0);
  endtask

  task automatic issue(input logic [31:0] w, input bit hold_after);
    int  waited;
    time hs;
    waited = 0;
    @(negedge in_clk);
    while (!out_instr_ready && waited < 4 * SLOT_LEN) begin
      in_instr       = $urandom;
      in_instr_valid = hold_mode ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge in_clk);
      waited++;
    end
    if (!out_instr_ready) begin
      check("ready_timeout", 64'(out_instr_ready), 64'd1);
      return;
    end
    in_instr       = w;
    in_instr_valid = 1'b1;
    q.push_back(model_decode(w, model_pc));
    model_pc += 32'd4;
    @(posedge in_clk);
    hs = $time;
    if (last_hold) check("throughput", 64'(hs - last_hs), 64'((SLOT_LEN + 1) * PERIOD));
    last_hs   = hs;
    last_hold = hold_after;
    hold_mode = hold_after;
    #1;
    in_instr = $urandom;
    if (!hold_after) in_instr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_instr_valid = 1'b0;
    hold_mode      = 0;
    last_hold      = 0;
    repeat (n) begin
      @(negedge in_clk);
      in_instr = $urandom;
    end
  endtask

  always @(negedge in_clk) begin
    if (!in_rst) begin
      prev   = IDLE;
      exp_pc = RESET_PC;
    end else begin
      if (prev == IDLE)      exp_next = (out_cycle_cnt == IDLE) ? IDLE : 4'd0;
      else if (prev == LAST) exp_next = IDLE;
      else                   exp_next = prev + 4'd1;
      check("cnt_seq", 64'(out_cycle_cnt), 64'(exp_next));
      if (out_cycle_cnt == 4'd0 && prev != 4'd0) begin
        check("slot_expected", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          cur = q.pop_front();
          check("start_en", 64'(en_v), 64'(cur.en));
          check("start_illegal", 64'(out_illegal), 64'(cur.ill));
          check("start_ready", 64'(out_instr_ready), 64'd0);
          check("start_pc", 64'(out_pc), 64'(cur.pc));
          if (cur.chk) begin
            check("start_imm", 64'(out_imm_type_i), 64'(cur.imm));
            check("start_rs1", 64'(out_rs1), 64'(cur.rs1));
            check("start_rd", 64'(out_rd), 64'(cur.rd));
          end
        end
      end else if (out_cycle_cnt != IDLE) begin
        if (cur.chk)
          check("slot_hold", 64'({en_v, out_imm_type_i, out_rs1, out_rd, out_illegal, out_instr_ready}),
                64'({cur.en, cur.imm, cur.rs1, cur.rd, 1'b0, 1'b0}));
        else
          check("slot_hold", 64'({en_v, out_illegal, out_instr_ready}), 64'd0);
        check("slot_pc", 64'(out_pc), 64'(cur.pc));
      end else begin
        if (prev == LAST) exp_pc = cur.pc + 32'd4;
        check("idle_outputs", 64'({en_v, out_illegal, out_instr_ready, out_halted, out_imm_type_i, out_rs1, out_rd}),
              64'({5'd0, 1'b0, 1'b1, 1'b0, 22'd0}));
        check("idle_pc", 64'(out_pc), 64'(exp_pc));
      end
      prev = out_cycle_cnt;
    end
  end

  initial begin
    int w;
    in_rst         = 1'b1;
    in_instr_valid = 1'b0;
    in_instr       = 32'h0;
    #1 in_rst = 1'b0;
    #2 check_reset_values("reset");
    repeat (2) @(negedge in_clk);
    in_rst = 1'b1;
    idle(2);

    issue(32'hFFD08293, 0);
    idle(SLOT_LEN + 2);

    issue(32'hFFD08293, 1);
    issue(32'h7FF06113, 0);
    idle(SLOT_LEN + 2);

    issue(32'h00000000, 0);
    idle(SLOT_LEN + 2);

    issue(32'hFFD08293, 0);
    w = 0;
    do begin
      @(negedge in_clk);
      w++;
    end while (out_cycle_cnt != 4'd3 && w < 4 * SLOT_LEN);
    check("reach_cnt3", 64'(out_cycle_cnt), 64'd3);
    #2 in_rst = 1'b0;
    #1 check_reset_values("midslot_reset");
    q.delete();
    model_pc  = RESET_PC;
    last_hold = 0;
    repeat (2) @(negedge in_clk);
    in_rst = 1'b1;
    idle(5);

    for (int i = 0; i < 40; i++) begin
      bit h;
      h = 1'($urandom_range(0, 1));
      issue(gen_instr(), h);
      if (!h && $urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    idle(1);
    w = 0;
    while ((q.size() != 0 || out_cycle_cnt != IDLE) && w < 4 * SLOT_LEN) begin
      @(negedge in_clk);
      w++;
    end
    check("drain", 64'(q.size()), 64'd0);
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
